// File: rtl/doorbell_pkg.sv
// Shared constants and debug state type for the doorbell handshake block.
package doorbell_pkg;

  localparam int DB_DEPTH = 4;

  typedef enum logic {
    DB_IDLE = 1'b0,
    DB_BUSY = 1'b1
  } db_state_e;

endpackage

// File: rtl/doorbell_sat_cnt.sv
// Saturating up/down counter of outstanding rings, clamped to [0, DEPTH].
// The next count is exported so the owner can register derived outputs in step with it.
module doorbell_sat_cnt
  import doorbell_pkg::*;
#(
  parameter int DEPTH = DB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             at_max,
  output logic             at_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_max    = (cnt_q == CNT_W'(DEPTH));
  assign at_zero   = (cnt_q == '0);
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

  // A simultaneous inc/dec cancels, except at zero where the dec has nothing to retire.
  always_comb begin
    cnt_d = cnt_q;
    case ({inc, dec})
      2'b10: if (!at_max)  cnt_d = cnt_q + CNT_W'(1);
      2'b01: if (!at_zero) cnt_d = cnt_q - CNT_W'(1);
      2'b11: if (at_zero)  cnt_d = CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/doorbell_ctrl.sv
// Doorbell handshake: counts rings against acknowledges, raises busy while any are outstanding,
// and records sticky overflow / spurious-acknowledge errors. All outputs come straight from flops.
module doorbell_ctrl
  import doorbell_pkg::*;
#(
  parameter int DEPTH = DB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             set_in,
  input  logic             done_in,
  output logic             busy_out,
  output logic [CNT_W-1:0] pending_out,
  output logic             overflow_out,
  output logic             spurious_out
);

  logic [CNT_W-1:0] cnt_nxt;
  logic             at_max, at_zero;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;
  logic             spur_q, spur_d;
  db_state_e        state_dbg;

  doorbell_sat_cnt #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .inc       (set_in),
    .dec       (done_in),
    .cnt_o     (pending_out),
    .cnt_nxt_o (cnt_nxt),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  // busy is registered from the counter's next value so it changes on the same edge as pending.
  always_comb begin
    busy_d = (cnt_nxt != '0);
    ovf_d  = ovf_q  | (set_in & ~done_in & at_max);
    spur_d = spur_q | (done_in & at_zero);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      spur_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      spur_q <= spur_d;
    end
  end

  assign busy_out     = busy_q;
  assign overflow_out = ovf_q;
  assign spurious_out = spur_q;

  assign state_dbg = (pending_out == '0) ? DB_IDLE : DB_BUSY;

  a_busy_matches_count: assert property (@(posedge clk) disable iff (!rstn)
    busy_out == (state_dbg == DB_BUSY));

  a_count_in_range: assert property (@(posedge clk) disable iff (!rstn)
    pending_out <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_doorbell_ctrl.sv
// Directed bench for doorbell_ctrl: a ring/acknowledge ledger model plus hand-computed pins.
module tb_doorbell_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             set_in = 1'b0;
  logic             done_in = 1'b0;
  logic             busy_out;
  logic [CNT_W-1:0] pending_out;
  logic             overflow_out;
  logic             spurious_out;

  doorbell_ctrl #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .set_in       (set_in),
    .done_in      (done_in),
    .busy_out     (busy_out),
    .pending_out  (pending_out),
    .overflow_out (overflow_out),
    .spurious_out (spurious_out)
  );

  always #5 clk = ~clk;

  // Ledger model: number of rings not yet acknowledged, plus the two error records.
  int m_cnt  = 0;
  int m_ovf  = 0;
  int m_spur = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cnt = 0; m_ovf = 0; m_spur = 0;
    end else if (set_in && done_in) begin
      if (m_cnt == 0) begin
        m_cnt = 1; m_spur = 1;
      end
    end else if (set_in) begin
      if (m_cnt == DEPTH) m_ovf = 1;
      else                m_cnt = m_cnt + 1;
    end else if (done_in) begin
      if (m_cnt == 0) m_spur = 1;
      else            m_cnt = m_cnt - 1;
    end
  end

  // Hand-computed expectations for the cycle being checked next.
  logic pin_busy = 1'b0;
  int   pin_pend = 0;
  logic pin_ovf  = 1'b0;
  logic pin_spur = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model_busy",     int'(busy_out),     int'(m_cnt != 0));
    check("model_pending",  int'(pending_out),  m_cnt);
    check("model_overflow", int'(overflow_out), m_ovf);
    check("model_spurious", int'(spurious_out), m_spur);
    check("pin_busy",       int'(busy_out),     int'(pin_busy));
    check("pin_pending",    int'(pending_out),  pin_pend);
    check("pin_overflow",   int'(overflow_out), int'(pin_ovf));
    check("pin_spurious",   int'(spurious_out), int'(pin_spur));
  end

  // Drive one cycle of inputs and state what the outputs must be after the next edge.
  task automatic step(input logic s, input logic d, input logic eb, input int ep,
                      input logic eo, input logic es);
    @(negedge clk);
    #1;
    set_in   = s;
    done_in  = d;
    pin_busy = eb;
    pin_pend = ep;
    pin_ovf  = eo;
    pin_spur = es;
  endtask

  initial begin
    // Reset held for two cycles, then released.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // Basic ring
    step(1, 0, 1, 1, 0, 0);
    repeat (5) step(0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);

    // Queued rings
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 2, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    step(0, 1, 1, 2, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Overflow at DEPTH=4
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 2, 0, 0);
    step(1, 0, 1, 3, 0, 0);
    step(1, 0, 1, 4, 0, 0);
    step(1, 0, 1, 4, 1, 0);
    step(0, 1, 1, 3, 1, 0);
    step(0, 1, 1, 2, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Simultaneous ring and acknowledge with two outstanding cancel out
    step(1, 0, 1, 1, 1, 0);
    step(1, 0, 1, 2, 1, 0);
    step(1, 1, 1, 2, 1, 0);
    step(0, 1, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0);

    // Both at zero: ring counts, acknowledge is spurious
    step(1, 1, 1, 1, 1, 1);
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Reset in the middle of a busy period, asserted between edges
    step(1, 0, 1, 1, 1, 1);
    step(1, 0, 1, 2, 1, 1);
    step(1, 0, 1, 3, 1, 1);
    step(0, 0, 1, 3, 1, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn     = 1'b0;
    pin_busy = 1'b0;
    pin_pend = 0;
    pin_ovf  = 1'b0;
    pin_spur = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // Basic ring again after the reset
    step(1, 0, 1, 1, 0, 0);
    repeat (5) step(0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Spurious acknowledge while idle, sticky afterwards
    step(0, 1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);

    @(negedge clk);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/doorbell_ctrl.md
# doorbell_ctrl

Single-clock doorbell handshake block: a producer "rings" with a one-cycle `set_in` pulse, and the block raises `busy_out` until the consumer acknowledges with `done_in`. Rings arriving while busy are counted, so every ring has exactly one acknowledge. It sits between a command producer (register write or DMA kick) and the engine that services the request.

## Interface
Parameters:
- `DEPTH`, default 4: maximum number of outstanding rings counted (≥1).
- `CNT_W`, default `$clog2(DEPTH+1)`: pending-counter width (derived; do not override).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `set_in`  in  1  ring request; each high cycle is one ring.
- `done_in`  in  1  acknowledge; each high cycle retires one ring.
- `busy_out`  out  1  high while at least one ring is outstanding.
- `pending_out`  out  `CNT_W`  outstanding ring count.
- `overflow_out`  out  1  sticky: a ring arrived while count == `DEPTH`.
- `spurious_out`  out  1  sticky: `done_in` arrived while count == 0.

## Operation
- States (from `pending_out`): IDLE (count 0) and BUSY (count > 0). `busy_out` = (count != 0), registered.
- Per rising edge, with count `c`:
  - `set_in` only: `c+1`. If `c == DEPTH`, `c` holds and `overflow_out` is set.
  - `done_in` only: `c-1`. If `c == 0`, `c` holds at 0 and `spurious_out` is set.
  - Both with `c > 0`: `c` unchanged. The ring and the acknowledge cancel.
  - Both with `c == 0`: `c` becomes 1. `done_in` is treated as spurious and `spurious_out` is set.
  - Neither: hold.
- The count never wraps. It saturates at 0 and at `DEPTH`.
- Sticky flags clear only on reset.
- Level-high inputs are counted once per cycle. Multi-cycle pulses are multiple rings or acknowledges.

## Timing
- Reset (`rstn` low, asynchronous): `busy_out`=0, `pending_out`=0, `overflow_out`=0, `spurious_out`=0. These values apply immediately, regardless of the clock.
- Reset release is synchronous in effect: the first edge with `rstn` high processes inputs normally.
- Latency: `set_in` sampled high at edge N gives `busy_out`=1 from edge N (visible after N), one cycle.
- `done_in` sampled at edge M, retiring the last ring, gives `busy_out`=0 after edge M.
- No combinational path from any input to any output.
- Reset asserted mid-operation discards all outstanding rings. `busy_out` drops immediately.

## Structure
- Package `doorbell_pkg`: holds the `DEPTH` default constant and the state enum `db_state_e` {`DB_IDLE`, `DB_BUSY`} used for debug/assertions.
- Sub-module `doorbell_sat_cnt`: saturating up/down counter, parameterised by `DEPTH`. It has `inc`/`dec` inputs and `at_max`/`at_zero` outputs.
- The top level holds the flag logic and the output registers.
- The block carries assertions:
  - `busy_out` == (`pending_out` != 0).
  - `pending_out` ≤ `DEPTH`.

## Test plan
- Basic ring: reset 1 cycle, release, then `set_in`=1 for 1 cycle, idle 5 cycles, then `done_in`=1 for 1 cycle, idle 5 cycles.
  - `busy_out`=0 during reset.
  - `busy_out`=1 from the edge sampling `set_in` through 5 idle cycles.
  - `busy_out`=0 after the `done_in` edge.
  - Both flags stay 0.
- Queued rings (`DEPTH`=4): 3 `set_in` pulses, then 3 `done_in` pulses.
  - `pending_out` steps 1,2,3 then 2,1,0.
  - `busy_out` falls only after the third acknowledge.
- Overflow: 5 `set_in` pulses with `DEPTH`=4.
  - `pending_out` saturates at 4.
  - `overflow_out`=1 from the 5th ring onward.
  - 4 acknowledges then return `busy_out` to 0.
- Spurious done: `done_in` pulse while idle.
  - `pending_out` stays 0 and `busy_out` stays 0.
  - `spurious_out`=1 and remains 1 until reset.
- Simultaneous events:
  - With `pending_out`=2, `set_in`=`done_in`=1 for 1 cycle: count stays 2.
  - With count 0, both high: count becomes 1 and `spurious_out`=1.
- Reset mid-busy: with `pending_out`=3, assert `rstn`=0 between clock edges.
  - All outputs go 0 immediately.
  - After release, a single ring/acknowledge pair behaves as in the basic-ring scenario.
